fa_serial_addsub: RTL and testbench

- Parametrised, digit-serial successor to the team's single-bit full adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock through one registered DIGIT-bit carry chain.
- Supports add, subtract, accumulate and load modes, with valid/ready handshakes on both input and output.
- Sits behind the tiny-tapeout I/O wrapper; the wrapper maps ui_in/uio_in onto the operand ports.

---
 rtl/fa_serial_addsub_if.sv | 28 ++
 rtl/fa_serial_addsub.sv | 189 ++++++++++++++++++
 tb/tb_fa_serial_addsub.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fa_serial_addsub_if.sv
// Command/result bus for the digit-serial add/subtract unit.
// The master issues commands and consumes results; the slave is the adder.
interface fa_serial_addsub_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, mode, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, mode, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/fa_serial_addsub.sv
// Digit-serial adder/subtractor with accumulator.
// Processes DIGIT bits per clock through a single registered carry, so an
// ADD/SUB/ACC takes N = WIDTH/DIGIT digit cycles; LOAD completes at once.
module fa_serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic                 clk,
    input logic                 rst,
    fa_serial_addsub_if.slave   bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int DW    = DIGIT + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    state_e             state_q,     state_d;
    mode_e              mode_q,      mode_d;
    logic [WIDTH-1:0]   x_q,         x_d;
    logic [WIDTH-1:0]   y_q,         y_d;
    logic [WIDTH-1:0]   res_q,       res_d;
    logic               carry_q,     carry_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   acc_q,       acc_d;
    logic [WIDTH-1:0]   sum_q,       sum_d;
    logic               cout_q,      cout_d;
    logic               ovf_q,       ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q,  in_ready_d;
    logic               busy_q,      busy_d;

    // One digit of the carry chain: low DIGIT bits of X and Y plus the carry.
    logic [DIGIT:0]     digit_sum;
    logic [WIDTH-1:0]   res_next;
    logic               ovf_next;

    assign digit_sum = {1'b0, x_q[DIGIT-1:0]} + {1'b0, y_q[DIGIT-1:0]} + DW'(carry_q);

    // The new digit enters from the MSB side; after N digits the LSB digit
    // has migrated to the bottom of the result register.
    assign res_next = (res_q >> DIGIT) | (WIDTH'(digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

    // Carry into the MSB is recovered from the MSB sum bit (s = x ^ y ^ c_in);
    // only meaningful on the last digit, where the MSB sits at DIGIT-1.
    assign ovf_next = x_q[DIGIT-1] ^ y_q[DIGIT-1] ^ digit_sum[DIGIT-1] ^ digit_sum[DIGIT];

    // Next-state, datapath and registered-output computation.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        mode_d    = mode_q;
        x_d       = x_q;
        y_d       = y_q;
        res_d     = res_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    mode_d = mode_e'(bus.mode);
                    cnt_d  = '0;
                    res_d  = '0;
                    case (mode_e'(bus.mode))
                        MODE_ADD: begin
                            x_d     = bus.a;
                            y_d     = bus.b;
                            carry_d = bus.cin;
                            state_d = S_CALC;
                        end
                        MODE_SUB: begin
                            x_d     = bus.a;
                            y_d     = ~bus.b;
                            carry_d = 1'b1;
                            state_d = S_CALC;
                        end
                        MODE_ACC: begin
                            x_d     = acc_q;
                            y_d     = bus.a;
                            carry_d = bus.cin;
                            state_d = S_CALC;
                        end
                        default: begin
                            acc_d   = bus.a;
                            sum_d   = bus.a;
                            cout_d  = 1'b0;
                            ovf_d   = 1'b0;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end

            S_CALC: begin
                x_d     = x_q >> DIGIT;
                y_d     = y_q >> DIGIT;
                res_d   = res_next;
                carry_d = digit_sum[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    sum_d   = res_next;
                    cout_d  = digit_sum[DIGIT];
                    ovf_d   = ovf_next;
                    if (mode_q == MODE_ACC) begin
                        acc_d = res_next;
                    end
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result is announced one edge after the result registers settle and
        // withdrawn on the handshake edge.
        out_valid_d = (state_q == S_DONE) && (state_d == S_DONE);
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers; synchronous reset discards any operation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_ADD;
            x_q         <= '0;
            y_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fa_serial_addsub.sv
// Bench for fa_serial_addsub: a bit-serial (DIGIT=1) and a nibble-serial
// (DIGIT=4) instance, checked against an integer-arithmetic model.
module tb_fa_serial_addsub;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared operand drive; in_valid is steered to one instance at a time.
    logic         iv8 = 1'b0;
    logic         iv4 = 1'b0;
    logic         out_rdy = 1'b1;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         op_cin = 1'b0;
    logic [1:0]   op_mode = 2'b00;
    logic         sel = 1'b0;

    fa_serial_addsub_if #(.WIDTH(W)) if8 ();
    fa_serial_addsub_if #(.WIDTH(W)) if4 ();

    assign if8.in_valid  = iv8;
    assign if8.a         = op_a;
    assign if8.b         = op_b;
    assign if8.cin       = op_cin;
    assign if8.mode      = op_mode;
    assign if8.out_ready = out_rdy;
    assign if4.in_valid  = iv4;
    assign if4.a         = op_a;
    assign if4.b         = op_b;
    assign if4.cin       = op_cin;
    assign if4.mode      = op_mode;
    assign if4.out_ready = out_rdy;

    fa_serial_addsub #(.WIDTH(W), .DIGIT(1)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    fa_serial_addsub #(.WIDTH(W), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    wire         m_in_ready  = sel ? if4.in_ready  : if8.in_ready;
    wire         m_out_valid = sel ? if4.out_valid : if8.out_valid;
    wire [W-1:0] m_sum       = sel ? if4.sum       : if8.sum;
    wire         m_cout      = sel ? if4.cout      : if8.cout;
    wire         m_ovf       = sel ? if4.ovf       : if8.ovf;
    wire         m_busy      = sel ? if4.busy      : if8.busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: accumulator per instance and last delivered result.
    logic [W-1:0] acc_m [2];
    logic [W-1:0] last_sum [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input bit s4, input logic [1:0] m, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c,
                         output logic [W-1:0] e_sum, output logic e_cout, output logic e_ovf);
        int u, s;
        case (m)
            2'b00: begin
                u = int'(a) + int'(b) + int'(c);
                s = int'($signed(a)) + int'($signed(b)) + int'(c);
            end
            2'b01: begin
                u = int'(a) - int'(b);
                s = int'($signed(a)) - int'($signed(b));
            end
            2'b10: begin
                u = int'(acc_m[s4]) + int'(a) + int'(c);
                s = int'($signed(acc_m[s4])) + int'($signed(a)) + int'(c);
            end
            default: begin
                u = int'(a);
                s = 0;
            end
        endcase
        e_sum  = W'(u);
        e_cout = (m == 2'b01) ? (a >= b) : (m == 2'b11) ? 1'b0 : (u > 255);
        e_ovf  = (s > 127) || (s < -128);
        if (m == 2'b10 || m == 2'b11) acc_m[s4] = e_sum;
    endtask

    // Issue one command, wait for out_valid, compare latency and result.
    task automatic run_op(input bit s4, input logic [1:0] m, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c, input string tag);
        logic [W-1:0] e_sum;
        logic         e_cout, e_ovf;
        int           lat, e_lat;
        sel = s4;
        e_lat = (m == 2'b11) ? 1 : ((s4 ? 2 : 8) + 1);
        model(s4, m, a, b, c, e_sum, e_cout, e_ovf);
        #0;
        check({tag, "_in_ready_pre"}, 32'(m_in_ready), 32'd1);
        op_a = a; op_b = b; op_cin = c; op_mode = m;
        if (s4) iv4 = 1'b1; else iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; iv4 = 1'b0;
        check({tag, "_busy"}, 32'(m_busy), 32'd1);
        check({tag, "_in_ready_busy"}, 32'(m_in_ready), 32'd0);
        // Scramble the operands: changes while busy must have no effect.
        op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom); op_mode = 2'($urandom);
        lat = 0;
        while (!m_out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(e_lat));
        check({tag, "_sum"}, 32'(m_sum), 32'(e_sum));
        check({tag, "_cout"}, 32'(m_cout), 32'(e_cout));
        check({tag, "_ovf"}, 32'(m_ovf), 32'(e_ovf));
        last_sum[s4] = e_sum;
    endtask

    // Complete the output handshake and confirm the return to IDLE.
    task automatic finish_op(input string tag);
        out_rdy = 1'b1;
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, 32'(m_out_valid), 32'd0);
        check({tag, "_in_ready_post"}, 32'(m_in_ready), 32'd1);
        check({tag, "_sum_hold"}, 32'(m_sum), 32'(last_sum[sel]));
    endtask

    initial begin
        acc_m[0] = '0; acc_m[1] = '0;
        last_sum[0] = '0; last_sum[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state of both instances.
        for (int i = 0; i < 2; i++) begin
            sel = 1'(i);
            #0;
            check("rst_in_ready", 32'(m_in_ready), 32'd1);
            check("rst_out_valid", 32'(m_out_valid), 32'd0);
            check("rst_busy", 32'(m_busy), 32'd0);
            check("rst_sum", 32'(m_sum), 32'd0);
            check("rst_cout", 32'(m_cout), 32'd0);
            check("rst_ovf", 32'(m_ovf), 32'd0);
        end

        // Directed cases.
        run_op(0, 2'b00, 8'h7F, 8'h01, 1'b0, "add_ovf");  finish_op("add_ovf");
        run_op(0, 2'b01, 8'h05, 8'h07, 1'b1, "sub_neg");  finish_op("sub_neg");
        run_op(0, 2'b01, 8'h80, 8'h01, 1'b0, "sub_ovf");  finish_op("sub_ovf");
        run_op(0, 2'b11, 8'h10, 8'hAA, 1'b1, "load");     finish_op("load");
        run_op(0, 2'b10, 8'h20, 8'h55, 1'b0, "acc1");     finish_op("acc1");
        run_op(0, 2'b10, 8'hF0, 8'h00, 1'b0, "acc2");     finish_op("acc2");
        run_op(1, 2'b00, 8'hFF, 8'h01, 1'b1, "d4_add");   finish_op("d4_add");

        // Backpressure: result must hold and no new command may enter.
        out_rdy = 1'b0;
        run_op(0, 2'b00, 8'h12, 8'h34, 1'b0, "bp");
        op_a = 8'h99; op_b = 8'h11; op_mode = 2'b11;
        iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_sum_stable", 32'(m_sum), 32'h46);
            check("bp_valid_held", 32'(m_out_valid), 32'd1);
            check("bp_in_ready", 32'(m_in_ready), 32'd0);
        end
        iv8 = 1'b0;
        finish_op("bp");

        // Reset in the middle of an ADD.
        sel = 1'b0;
        op_a = 8'h3C; op_b = 8'h5A; op_cin = 1'b0; op_mode = 2'b00;
        iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        acc_m[0] = '0; acc_m[1] = '0;
        last_sum[0] = '0; last_sum[1] = '0;
        check("midrst_out_valid", 32'(m_out_valid), 32'd0);
        check("midrst_sum", 32'(m_sum), 32'd0);
        check("midrst_in_ready", 32'(m_in_ready), 32'd1);
        check("midrst_busy", 32'(m_busy), 32'd0);
        run_op(0, 2'b10, 8'h05, 8'h00, 1'b0, "midrst_acc"); finish_op("midrst_acc");
        run_op(0, 2'b00, 8'h01, 8'h01, 1'b0, "midrst_add"); finish_op("midrst_add");

        // Randomized traffic on both instances, occasional backpressure.
        for (int i = 0; i < 40; i++) begin
            bit s4;
            int stall;
            s4 = ($urandom_range(0, 3) == 0);
            stall = $urandom_range(0, 3);
            out_rdy = (stall == 0);
            run_op(s4, 2'($urandom), W'($urandom), W'($urandom), 1'($urandom), "rnd");
            repeat (stall) @(posedge clk);
            #0;
            check("rnd_sum_stall", 32'(m_sum), 32'(last_sum[s4]));
            finish_op("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Watchdog: the run is far shorter than this.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end
endmodule
